// File: rtl/branch_predictor.sv
// 16-entry direct-mapped BTB with 2-bit saturating counters and execute-stage resolution.
// Optional performance counters are enabled by defining BP_PERF_CNT_EN.
module branch_predictor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  output logic        MispredictE,
  output logic [1:0]  RedirectSelE,
  output logic        FlushDE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int ENTRIES = 16;

  logic        valid  [ENTRIES];
  logic [5:0]  tag    [ENTRIES];
  logic [1:0]  ctr    [ENTRIES];
  logic [31:0] target [ENTRIES];

  logic [3:0] idx_f, idx_e;
  logic [5:0] tag_f, tag_e;
  logic       hit_f, hit_e, resolve, taken;
  logic       unused_pc_bits;

  assign idx_f = PCF[5:2];
  assign tag_f = PCF[11:6];
  assign idx_e = PCE[5:2];
  assign tag_e = PCE[11:6];
  assign unused_pc_bits = ^{PCF[31:12], PCF[1:0], PCE[31:12], PCE[1:0]};

  // Lookup reads the registered table, so a same-cycle update is never visible here.
  assign hit_f       = valid[idx_f] && (tag[idx_f] == tag_f);
  assign PredTakenF  = hit_f & ctr[idx_f][1];
  assign PredTargetF = PredTakenF ? target[idx_f] : PCF + 32'd4;

  assign hit_e   = valid[idx_e] && (tag[idx_e] == tag_e);
  assign resolve = BranchE | JumpE;
  assign taken   = |PCSrcE;

  assign MispredictE = resolve & ((taken != PredTakenE) |
                                  (taken & PredTakenE & (PredTargetE != PCTargetE)));
  assign FlushDE     = MispredictE;

  always_comb begin
    RedirectSelE = 2'b00;
    if (MispredictE) RedirectSelE = taken ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        ctr[i]    <= 2'b01;
        target[i] <= '0;
      end
    end else if (resolve) begin
      if (hit_e) begin
        if (taken) begin
          if (ctr[idx_e] != 2'b11) ctr[idx_e] <= ctr[idx_e] + 2'd1;
          target[idx_e] <= PCTargetE;
        end else if (ctr[idx_e] != 2'b00) begin
          ctr[idx_e] <= ctr[idx_e] - 2'd1;
        end
      end else if (taken) begin
        // A jump (including branch+jump together) allocates strongly taken.
        valid[idx_e]  <= 1'b1;
        tag[idx_e]    <= tag_e;
        target[idx_e] <= PCTargetE;
        ctr[idx_e]    <= JumpE ? 2'b11 : 2'b10;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt, mispred_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve)     branch_cnt  <= branch_cnt + 32'd1;
      if (MispredictE) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign BranchCnt  = branch_cnt;
  assign MispredCnt = mispred_cnt;
`else
  assign BranchCnt  = '0;
  assign MispredCnt = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a behavioural BTB model. Honors BP_PERF_CNT_EN for counter expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PCF = '0, PCE = '0, PCTargetE = '0, PredTargetE = '0;
  logic        BranchE = 1'b0, JumpE = 1'b0, PredTakenE = 1'b0;
  logic [1:0]  PCSrcE = '0;
  logic        PredTakenF, MispredictE, FlushDE;
  logic [31:0] PredTargetF, BranchCnt, MispredCnt;
  logic [1:0]  RedirectSelE;

  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PCE(PCE), .BranchE(BranchE), .JumpE(JumpE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF), .MispredictE(MispredictE),
    .RedirectSelE(RedirectSelE), .FlushDE(FlushDE), .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: table slot = (pc/4) mod 16, tag = (pc/64) mod 64, counter kept as 0..3.
  bit          m_valid  [16];
  int          m_tag    [16];
  int          m_ctr    [16];
  logic [31:0] m_target [16];
  int unsigned m_bcnt, m_mcnt;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_target[i] = '0;
    end
    m_bcnt = 0; m_mcnt = 0;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int slot;
    slot = int'((pc / 4) % 16);
    return m_valid[slot] && (m_tag[slot] == int'((pc / 64) % 64));
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int slot;
    slot = int'((pc / 4) % 16);
    t  = m_hit(pc) && (m_ctr[slot] >= 2);
    tg = t ? m_target[slot] : pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    bit res, tk;
    res = BranchE || JumpE;
    tk  = (PCSrcE != 2'b00);
    return res && ((tk != PredTakenE) || (tk && PredTakenE && (PredTargetE != PCTargetE)));
  endfunction

  function automatic logic [1:0] m_redirect();
    if (!m_mispredict()) return 2'b00;
    return (PCSrcE != 2'b00) ? 2'b01 : 2'b10;
  endfunction

  function automatic void m_update();
    int slot;
    bit res, tk, hit;
    if (!rst_n) begin
      m_reset();
      return;
    end
    res  = BranchE || JumpE;
    tk   = (PCSrcE != 2'b00);
    slot = int'((PCE / 4) % 16);
    hit  = m_hit(PCE);
    if (res) m_bcnt++;
    if (m_mispredict()) m_mcnt++;
    if (!res) return;
    if (hit) begin
      if (tk) begin
        if (m_ctr[slot] < 3) m_ctr[slot]++;
        m_target[slot] = PCTargetE;
      end else if (m_ctr[slot] > 0) begin
        m_ctr[slot]--;
      end
    end else if (tk) begin
      m_valid[slot]  = 1;
      m_tag[slot]    = int'((PCE / 64) % 64);
      m_target[slot] = PCTargetE;
      m_ctr[slot]    = JumpE ? 3 : 2;
    end
  endfunction

  task automatic drive(input bit br, input bit jp, input logic [1:0] src, input logic [31:0] pce,
                       input logic [31:0] tgt, input bit pt, input logic [31:0] ptg,
                       input logic [31:0] pcf);
    BranchE = br; JumpE = jp; PCSrcE = src; PCE = pce; PCTargetE = tgt;
    PredTakenE = pt; PredTargetE = ptg; PCF = pcf;
    #1;
  endtask

  task automatic idle(input logic [31:0] pcf);
    drive(0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, pcf);
  endtask

  task automatic tick();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m_reset();
    idle(32'h40);
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred_taken got %0b exp 0", PredTakenF); end
    checks++; if (PredTargetF !== 32'h44) begin errors++; $display("[TB] FAIL reset_pred_target got %h exp 00000044", PredTargetF); end
    checks++; if (MispredictE !== 1'b0 || RedirectSelE !== 2'b00 || FlushDE !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_resolve got mis=%0b sel=%0b flush=%0b exp 0/00/0", MispredictE, RedirectSelE, FlushDE);
    end
    checks++; if (BranchCnt !== 32'h0 || MispredCnt !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_counters got %h/%h exp 0/0", BranchCnt, MispredCnt);
    end
    // A taken resolve while reset is held must not allocate anything.
    drive(1, 0, 2'b01, 32'h40, 32'h100, 0, 32'h0, 32'h40);
    tick();
    tick();
    idle(32'h40);
    rst_n = 1'b1;
    #1;
    checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h44) begin
      errors++; $display("[TB] FAIL reset_held_write got %0b/%h exp 0/00000044", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_cold_miss();
    drive(1, 0, 2'b01, 32'h40, 32'h100, 0, 32'h0, 32'h0);
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("[TB] FAIL cold_mispredict got %0b exp 1", MispredictE); end
    checks++; if (RedirectSelE !== 2'b01) begin errors++; $display("[TB] FAIL cold_redirect got %b exp 01", RedirectSelE); end
    checks++; if (FlushDE !== 1'b1) begin errors++; $display("[TB] FAIL cold_flush got %0b exp 1", FlushDE); end
    tick();
    idle(32'h40);
    checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h100) begin
      errors++; $display("[TB] FAIL cold_lookup got %0b/%h exp 1/00000100", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 2'b01, 32'h40, 32'h100, 1, 32'h100, 32'h40);
      checks++; if (MispredictE !== 1'b0) begin errors++; $display("[TB] FAIL sat_taken_mis[%0d] got %0b exp 0", i, MispredictE); end
      tick();
    end
    drive(1, 0, 2'b00, 32'h40, 32'h100, 1, 32'h100, 32'h40);
    checks++; if (RedirectSelE !== 2'b10 || MispredictE !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_nottaken_redirect got sel=%b mis=%0b exp 10/1", RedirectSelE, MispredictE);
    end
    tick();
    idle(32'h40);
    checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h100) begin
      errors++; $display("[TB] FAIL sat_hysteresis got %0b/%h exp 1/00000100", PredTakenF, PredTargetF);
    end
    drive(1, 0, 2'b00, 32'h40, 32'h100, 1, 32'h100, 32'h40);
    tick();
    idle(32'h40);
    checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h44) begin
      errors++; $display("[TB] FAIL sat_weak_not_taken got %0b/%h exp 0/00000044", PredTakenF, PredTargetF);
    end
    // Two more not-taken pin the counter at its floor; one taken must not predict taken yet.
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 2'b00, 32'h40, 32'h100, 0, 32'h0, 32'h40);
      tick();
    end
    drive(1, 0, 2'b01, 32'h40, 32'h100, 0, 32'h0, 32'h40);
    tick();
    idle(32'h40);
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("[TB] FAIL sat_floor got %0b exp 0", PredTakenF); end
    drive(1, 0, 2'b01, 32'h40, 32'h100, 0, 32'h0, 32'h40);
    tick();
    idle(32'h40);
    checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h100) begin
      errors++; $display("[TB] FAIL sat_recover got %0b/%h exp 1/00000100", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_wrong_target();
    drive(1, 0, 2'b01, 32'h40, 32'h200, 1, 32'h100, 32'h40);
    checks++; if (MispredictE !== 1'b1 || RedirectSelE !== 2'b01) begin
      errors++; $display("[TB] FAIL wrong_target_resolve got mis=%0b sel=%b exp 1/01", MispredictE, RedirectSelE);
    end
    checks++; if (PredTargetF !== 32'h100) begin errors++; $display("[TB] FAIL wrong_target_rbw got %h exp 00000100", PredTargetF); end
    tick();
    idle(32'h40);
    checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h200) begin
      errors++; $display("[TB] FAIL wrong_target_update got %0b/%h exp 1/00000200", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_alias();
    drive(1, 0, 2'b01, 32'h840, 32'h300, 0, 32'h0, 32'h40);
    checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h200) begin
      errors++; $display("[TB] FAIL alias_same_cycle got %0b/%h exp 1/00000200", PredTakenF, PredTargetF);
    end
    tick();
    idle(32'h40);
    checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h44) begin
      errors++; $display("[TB] FAIL alias_old_evicted got %0b/%h exp 0/00000044", PredTakenF, PredTargetF);
    end
    idle(32'h840);
    checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h300) begin
      errors++; $display("[TB] FAIL alias_new_entry got %0b/%h exp 1/00000300", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_jump_priority();
    // Branch and jump together allocate strongly taken, so one not-taken leaves it predicting taken.
    drive(1, 1, 2'b01, 32'h80, 32'h500, 0, 32'h0, 32'h0);
    tick();
    drive(1, 0, 2'b00, 32'h80, 32'h500, 1, 32'h500, 32'h80);
    tick();
    idle(32'h80);
    checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h500) begin
      errors++; $display("[TB] FAIL jump_priority got %0b/%h exp 1/00000500", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_random();
    bit          et, pt, br, jp;
    logic [31:0] etg, ptg, pce, pcf, tgt;
    logic [31:0] exp_b, exp_m;
    for (int n = 0; n < 400; n++) begin
      pce = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 2)) << 6);
      pcf = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 2)) << 6);
      tgt = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
      br  = ($urandom_range(0, 3) != 0);
      jp  = ($urandom_range(0, 5) == 0);
      m_lookup(pce, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin
        pt  = $urandom_range(0, 1) != 0;
        ptg = tgt;
      end
      drive(br, jp, 2'($urandom_range(0, 3)), pce, tgt, pt, ptg, pcf);
      m_lookup(pcf, et, etg);
`ifdef BP_PERF_CNT_EN
      exp_b = m_bcnt; exp_m = m_mcnt;
`else
      exp_b = 32'h0; exp_m = 32'h0;
`endif
      checks++; if (PredTakenF !== et) begin errors++; $display("[TB] FAIL rand_pred_taken[%0d] got %0b exp %0b", n, PredTakenF, et); end
      checks++; if (PredTargetF !== etg) begin errors++; $display("[TB] FAIL rand_pred_target[%0d] got %h exp %h", n, PredTargetF, etg); end
      checks++; if (MispredictE !== m_mispredict() || FlushDE !== m_mispredict()) begin
        errors++; $display("[TB] FAIL rand_mispredict[%0d] got %0b/%0b exp %0b", n, MispredictE, FlushDE, m_mispredict());
      end
      checks++; if (RedirectSelE !== m_redirect()) begin errors++; $display("[TB] FAIL rand_redirect[%0d] got %b exp %b", n, RedirectSelE, m_redirect()); end
      checks++; if (BranchCnt !== exp_b || MispredCnt !== exp_m) begin
        errors++; $display("[TB] FAIL rand_counters[%0d] got %h/%h exp %h/%h", n, BranchCnt, MispredCnt, exp_b, exp_m);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    drive(1, 0, 2'b01, 32'hC0, 32'h700, 0, 32'h0, 32'h840);
    rst_n = 1'b0;
    #1;
    checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h844) begin
      errors++; $display("[TB] FAIL midreset_lookup got %0b/%h exp 0/00000844", PredTakenF, PredTargetF);
    end
    checks++; if (BranchCnt !== 32'h0 || MispredCnt !== 32'h0) begin
      errors++; $display("[TB] FAIL midreset_counters got %h/%h exp 0/0", BranchCnt, MispredCnt);
    end
    tick();
    idle(32'hC0);
    rst_n = 1'b1;
    #1;
    checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'hC4) begin
      errors++; $display("[TB] FAIL midreset_discard got %0b/%h exp 0/000000c4", PredTakenF, PredTargetF);
    end
    checks++; if (MispredictE !== 1'b0 || RedirectSelE !== 2'b00 || FlushDE !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_outputs got %0b/%b/%0b exp 0/00/0", MispredictE, RedirectSelE, FlushDE);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_saturation();
    test_wrong_target();
    test_alias();
    test_jump_priority();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below (clock and reset first).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  reset; asynchronous assert, active low.
REQ-004 PCF  in  32  fetch-stage PC used for lookup.
REQ-005 PCE  in  32  execute-stage PC of the instruction being resolved.
REQ-006 BranchE  in  1  conditional branch in execute.
REQ-007 JumpE  in  1  unconditional jump (jal/jalr) in execute.
REQ-008 PCSrcE  in  2  resolved PC select from the execute controller; nonzero means taken.
REQ-009 PCTargetE  in  32  resolved taken target.
REQ-010 PredTakenE  in  1  prediction carried down the pipe with the instruction.
REQ-011 PredTargetE  in  32  predicted target carried down the pipe.
REQ-012 PredTakenF  out  1  fetch-stage taken prediction.
REQ-013 PredTargetF  out  32  fetch-stage predicted target.
REQ-014 MispredictE  out  1  execute-stage resolution differs from the prediction.
REQ-015 RedirectSelE  out  2  00 none, 01 use PCTargetE, 10 use PCE+4.
REQ-016 FlushDE  out  1  flush the decode and execute pipeline registers.
REQ-017 BranchCnt, MispredCnt  out  32 each  performance counters (see Configuration).

Function
REQ-018 Table: 16 entries, each holding valid, 6-bit tag, 2-bit saturating counter and 32-bit target; index = PC[5:2], tag = PC[11:6].
REQ-019 Lookup is combinational, zero latency: PredTakenF = valid & tag match & counter[1]; PredTargetF = entry target when PredTakenF=1, otherwise PCF+4.
REQ-020 Resolve when BranchE|JumpE: taken = |PCSrcE.
REQ-021 MispredictE = resolve & ((taken != PredTakenE) | (taken & PredTakenE & PredTargetE != PCTargetE)).
REQ-022 RedirectSelE = 01 when MispredictE & taken; 10 when MispredictE & ~taken; 00 otherwise. FlushDE = MispredictE, in the same cycle.
REQ-023 On resolve with a tag hit, the counter SHALL update at the clock edge: +1 if taken, -1 if not; it SHALL saturate at 11 and 00; the target SHALL be written with PCTargetE when taken.
REQ-024 On resolve with a miss, the entry SHALL be allocated only if taken: valid=1, new tag, target=PCTargetE, counter=11 for JumpE and 10 for BranchE. A not-taken miss SHALL leave the table unchanged.
REQ-025 If the lookup and the update hit the same entry in one cycle, the lookup SHALL return the pre-update contents (read-before-write).
REQ-026 BranchE and JumpE both high SHALL be treated as JumpE.
REQ-027 Outputs SHALL depend only on current inputs and table state; the block SHALL NOT stall the pipeline.

Reset
REQ-028 While rst_n=0: all valid bits=0, all counters=01, tags and targets=0, counters BranchCnt/MispredCnt=0.
REQ-029 Reset mid-update SHALL discard the in-flight write; the first lookup after release SHALL miss (PredTakenF=0, PredTargetF=PCF+4).

Configuration
REQ-030 Macro BP_PERF_CNT_EN defined: BranchCnt SHALL increment on every resolve and MispredCnt on every MispredictE cycle; both SHALL be 32-bit and wrap from FFFFFFFF to 0.
REQ-031 Macro BP_PERF_CNT_EN undefined: BranchCnt and MispredCnt SHALL be tied to 0, no counter flops SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-032 Cold miss: after reset, BranchE=1, PCE=0x40, PCSrcE=01, PCTargetE=0x100, PredTakenE=0 -> MispredictE=1, RedirectSelE=01, FlushDE=1; next cycle PCF=0x40 -> PredTakenF=1, PredTargetF=0x100.
REQ-033 Saturation and hysteresis: four taken resolves at PC 0x40 then one not-taken -> counter 11 then 10, and PredTakenF stays 1; a second not-taken -> counter 01, PredTakenF=0.
REQ-034 Wrong target: hit with PredTakenE=1, PredTargetE=0x100, PCTargetE=0x200 -> MispredictE=1, RedirectSelE=01; entry target becomes 0x200.
REQ-035 Alias and same-cycle conflict: PCF=0x40 lookup while PCE=0x840 resolves taken -> PredTakenF reflects the old entry; next cycle PC 0x40 misses (tag replaced).
REQ-036 Counter wrap and reset: with BP_PERF_CNT_EN, preload MispredCnt=FFFFFFFF and then mispredict -> MispredCnt=0; assert rst_n mid-run -> all outputs return to their reset values.
